// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative RV64 M-extension multiply/divide sequencer
// Build option: define MD_FAST_MUL_EN for a single-cycle multiply path (divide stays iterative).
// op_i encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
module md_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      op_i,
   input  logic            word_op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic            is_div;
   logic            is_rem;
   logic            is_high;
   logic            word_r;
   logic            neg_r;
   logic [5:0]      cnt;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] opnd_b;
   logic [4:0]      tag_r;

   logic            in_div, in_rem, in_signed_div, in_high;
   logic            sign_a, sign_b, a_neg, b_neg, in_neg;
   logic [XLEN-1:0] opa, opb, inv_a, inv_b, mag_a, mag_b;
   logic            b_zero, ovf, special;
   logic [XLEN-1:0] special_res;

   logic [XLEN:0]    mul_sum;
   logic [XLEN:0]    div_shift;
   logic             div_ge;
   logic [XLEN-1:0]  div_sub;
   logic [XLEN-1:0]  nxt_hi, nxt_lo;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]  quot, dval, dval_s, fin;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   assign req_ready_o = (state == IDLE) && !flush_i;
   assign busy_o      = (state != IDLE);

   // Decode the incoming request: operand magnitudes, result sign and divide special cases.
   always_comb begin
      in_div        = op_i[2];
      in_rem        = op_i[2] & op_i[1];
      in_signed_div = op_i[2] & ~op_i[0];
      // W forms of MULH* collapse onto MULW, so only 64-bit MULH* take the upper half
      in_high       = ~op_i[2] & ~word_op_i & (op_i[1:0] != 2'b00);
      sign_a        = in_div ? in_signed_div : (in_high & (op_i[1:0] != 2'b11));
      sign_b        = in_div ? in_signed_div : (in_high & (op_i[1:0] == 2'b01));
      opa           = word_op_i ? {32'b0, rs1_i[31:0]} : rs1_i;
      opb           = word_op_i ? {32'b0, rs2_i[31:0]} : rs2_i;
      a_neg         = sign_a & (word_op_i ? rs1_i[31] : rs1_i[63]);
      b_neg         = sign_b & (word_op_i ? rs2_i[31] : rs2_i[63]);
      inv_a         = ~opa + 64'd1;
      inv_b         = ~opb + 64'd1;
      mag_a         = a_neg ? (word_op_i ? {32'b0, inv_a[31:0]} : inv_a) : opa;
      mag_b         = b_neg ? (word_op_i ? {32'b0, inv_b[31:0]} : inv_b) : opb;
      // the remainder follows the dividend; everything else follows the operand signs
      in_neg        = (in_div & in_rem) ? a_neg : (a_neg ^ b_neg);
      b_zero        = word_op_i ? (rs2_i[31:0] == 32'd0) : (rs2_i == 64'd0);
      ovf           = in_signed_div & (word_op_i ?
                         (rs1_i[31:0] == 32'h8000_0000 && rs2_i[31:0] == 32'hFFFF_FFFF) :
                         (rs1_i == {1'b1, 63'b0} && rs2_i == {64{1'b1}}));
      special       = in_div & (b_zero | ovf);
      if (b_zero)
         special_res = in_rem ? (word_op_i ? sext32(rs1_i[31:0]) : rs1_i) : {64{1'b1}};
      else
         special_res = in_rem ? 64'd0 : (word_op_i ? 64'hFFFF_FFFF_8000_0000 : {1'b1, 63'b0});
   end

`ifdef MD_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fa, fb;
   logic [2*XLEN-1:0]        fprod;
   logic [XLEN-1:0]          fast_res;

   // Single-cycle product of the 65-bit sign/zero-extended operands.
   always_comb begin
      fa       = {{64{sign_a & rs1_i[63]}}, opa};
      fb       = {{64{sign_b & rs2_i[63]}}, opb};
      fprod    = fa * fb;
      fast_res = in_high ? fprod[127:64] : (word_op_i ? sext32(fprod[31:0]) : fprod[63:0]);
   end
`endif

   // One shift-add or restoring-divide step, plus the sign fix-up of the step's outcome.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 65'd0);
      div_shift = {acc_hi, acc_lo[63]};
      div_ge    = div_shift >= {1'b0, opnd_b};
      div_sub   = 64'(div_shift - {1'b0, opnd_b});
      if (is_div) begin
         nxt_hi = div_ge ? div_sub : div_shift[63:0];
         nxt_lo = {acc_lo[62:0], div_ge};
      end else begin
         nxt_hi = mul_sum[64:1];
         nxt_lo = {mul_sum[0], acc_lo[63:1]};
      end
      // a 32-bit multiply has only been shifted 32 places, so its product straddles hi/lo
      prod   = word_r ? {64'b0, nxt_hi[31:0], nxt_lo[63:32]} : {nxt_hi, nxt_lo};
      prod_s = neg_r ? (~prod + 128'd1) : prod;
      quot   = word_r ? {32'b0, nxt_lo[31:0]} : nxt_lo;
      dval   = is_rem ? nxt_hi : quot;
      dval_s = neg_r ? (~dval + 64'd1) : dval;
      if (is_div)
         fin = word_r ? sext32(dval_s[31:0]) : dval_s;
      else if (is_high)
         fin = prod_s[127:64];
      else
         fin = word_r ? sext32(prod_s[31:0]) : prod_s[63:0];
   end

   // Sequencer FSM: accept, iterate, then hold the registered response until consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         resp_valid_o <= 1'b0;
         result_o     <= '0;
         rd_o         <= '0;
         is_div       <= 1'b0;
         is_rem       <= 1'b0;
         is_high      <= 1'b0;
         word_r       <= 1'b0;
         neg_r        <= 1'b0;
         cnt          <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         opnd_b       <= '0;
         tag_r        <= '0;
      end else if (flush_i) begin
         state        <= IDLE;
         resp_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  tag_r   <= rd_i;
                  word_r  <= word_op_i;
                  is_div  <= in_div;
                  is_rem  <= in_rem;
                  is_high <= in_high;
                  neg_r   <= in_neg;
                  cnt     <= '0;
                  acc_hi  <= '0;
                  // a 32-bit dividend is parked at the top so quotient bits land in [31:0]
                  acc_lo  <= (in_div && word_op_i) ? {mag_a[31:0], 32'b0} : mag_a;
                  opnd_b  <= mag_b;
                  if (special) begin
                     state        <= DONE;
                     resp_valid_o <= 1'b1;
                     result_o     <= special_res;
                     rd_o         <= rd_i;
                  end
`ifdef MD_FAST_MUL_EN
                  else if (!in_div) begin
                     state        <= DONE;
                     resp_valid_o <= 1'b1;
                     result_o     <= fast_res;
                     rd_o         <= rd_i;
                  end
`endif
                  else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 6'd1;
               if (cnt == {~word_r, 5'h1f}) begin
                  state        <= DONE;
                  resp_valid_o <= 1'b1;
                  result_o     <= fin;
                  rd_o         <= tag_r;
               end
            end
            DONE: begin
               if (resp_ready_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               resp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer
`timescale 1ns/1ps
module tb_md_sequencer;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
`ifdef MD_FAST_MUL_EN
   localparam int MULW_LAT = 1;
`else
   localparam int MULW_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        word_op = 1'b0;
   logic [63:0] rs1 = '0;
   logic [63:0] rs2 = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic        resp_ready = 1'b0;
   wire         req_ready, resp_valid, busy;
   wire  [63:0] result;
   wire  [4:0]  rd_out;

   md_sequencer #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .op_i(op), .word_op_i(word_op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
      .flush_i(flush), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .result_o(result), .rd_o(rd_out), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // model state: one outstanding op at most
   logic        pend = 1'b0;
   int          acc_cyc = 0;
   int          due = 0;
   logic [63:0] exp_res = '0;
   logic [4:0]  exp_rd = '0;
   logic        chk_en = 1'b0;
   logic        ev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] p;
      logic signed [63:0]  sa, sb;
      logic [63:0]         ua, ub, r, t;
      if (!o[2]) begin
         if (w) begin
            t = a[31:0] * b[31:0];
            return sx(t[31:0]);
         end
         case (o)
            MUL:     return a * b;
            MULH:    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
            MULHSU:  p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
            default: p = {64'b0, a} * {64'b0, b};
         endcase
         return p[127:64];
      end
      sa = w ? sx(a[31:0]) : a;
      sb = w ? sx(b[31:0]) : b;
      ua = w ? {32'b0, a[31:0]} : a;
      ub = w ? {32'b0, b[31:0]} : b;
      if (!o[0]) begin
         if (sb == 0)                     r = o[1] ? sa : ONES;
         else if (!w && sa == MIN && sb == -1) r = o[1] ? 64'd0 : MIN;
         else                             r = o[1] ? (sa % sb) : (sa / sb);
      end else begin
         if (ub == 0) r = o[1] ? ua : ONES;
         else         r = o[1] ? (ua % ub) : (ua / ub);
      end
      return w ? sx(r[31:0]) : r;
   endfunction

   function automatic int lat(input logic [2:0] o, input logic w,
                              input logic [63:0] a, input logic [63:0] b);
      int wd;
      wd = w ? 32 : 64;
      if (!o[2]) begin
`ifdef MD_FAST_MUL_EN
         return 1;
`else
         return wd + 1;
`endif
      end
      if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
      if (!o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == MIN && b == ONES))) return 1;
      return wd + 1;
   endfunction

   // Per-cycle comparison of the DUT handshake and payload against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         ev = pend && (cyc >= due);
         check("resp_valid", {63'b0, resp_valid}, {63'b0, ev});
         check("busy", {63'b0, busy}, {63'b0, pend && (cyc > acc_cyc)});
         check("req_ready", {63'b0, req_ready}, {63'b0, !flush && !(pend && (cyc > acc_cyc))});
         if (ev) begin
            check("result", result, exp_res);
            check("rd", {59'b0, rd_out}, {59'b0, exp_rd});
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t);
      op = o; word_op = w; rs1 = a; rs2 = b; rd = t; req_valid = 1'b1;
      exp_res = model(o, w, a, b);
      exp_rd  = t;
      acc_cyc = cyc;
      due     = cyc + lat(o, w, a, b);
      pend    = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; rs1 = ~a; rs2 = ~b; rd = ~t; op = ~o;
   endtask

   task automatic finish_resp(input int stall, input logic fl);
      int guard;
      guard = 0;
      while (cyc < due && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (stall) begin @(posedge clk); #1; end
      resp_ready = 1'b1; flush = fl;
      @(posedge clk); #1;
      resp_ready = 1'b0; flush = 1'b0; pend = 1'b0;
   endtask

   task automatic run(input logic [2:0] o, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] t, input int stall);
      issue(o, w, a, b, t);
      finish_resp(stall, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // hand-computed values pinning the model
      check("pin div -7/2",    model(DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      check("pin rem -7%2",    model(REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), ONES);
      check("pin divu /0",     model(DIVU, 0, 64'h1234, 64'd0), ONES);
      check("pin remu %0",     model(REMU, 0, 64'h1234, 64'd0), 64'h1234);
      check("pin divw /0",     model(DIV, 1, 64'h5, 64'hFFFF_FFFF_0000_0000), ONES);
      check("pin div ovf",     model(DIV, 0, MIN, ONES), MIN);
      check("pin rem ovf",     model(REM, 0, MIN, ONES), 64'd0);
      check("pin divw ovf",    model(DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
      check("pin mulw",        model(MUL, 1, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
      check("pin mulhu",       model(MULHU, 0, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
      check("pin mulh",        model(MULH, 0, ONES, ONES), 64'd0);
      check("pin mulhsu",      model(MULHSU, 0, ONES, 64'd2), ONES);
      check("pin divu 100/7",  model(DIVU, 0, 64'd100, 64'd7), 64'd14);
      check("pin lat div",     64'(lat(DIV, 0, 64'd5, 64'd2)), 64'd65);
      check("pin lat special", 64'(lat(DIVU, 0, 64'h1234, 64'd0)), 64'd1);
      check("pin lat mulw",    64'(lat(MUL, 1, 64'd3, 64'd2)), 64'(MULW_LAT));

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset resp_valid", {63'b0, resp_valid}, 64'd0);
      check("reset busy", {63'b0, busy}, 64'd0);
      check("reset result", result, 64'd0);
      check("reset rd", {59'b0, rd_out}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk_en = 1'b1;

      run(DIV,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 0);
      run(REM,    0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 1);
      run(DIVU,   0, 64'h1234, 64'd0, 5'd3, 0);
      run(REMU,   0, 64'h1234, 64'd0, 5'd4, 2);
      run(DIV,    1, 64'h5, 64'hFFFF_FFFF_0000_0000, 5'd5, 0);
      run(DIV,    0, MIN, ONES, 5'd6, 0);
      run(REM,    0, MIN, ONES, 5'd7, 1);
      run(DIV,    1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd8, 0);
      run(MUL,    1, 64'h7FFF_FFFF, 64'd2, 5'd9, 0);
      run(MULHU,  0, ONES, ONES, 5'd10, 0);
      run(MULH,   0, ONES, ONES, 5'd11, 1);
      run(MULHSU, 0, ONES, 64'd2, 5'd12, 0);
      run(DIVU,   0, 64'd100, 64'd7, 5'd13, 10);
      run(MUL,    0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd14, 0);
      run(MULH,   0, MIN, 64'h7FFF_FFFF_FFFF_FFFF, 5'd15, 0);
      run(MULHSU, 0, 64'hFFFF_FFFF_0000_0001, 64'hF000_0000_0000_0003, 5'd16, 0);
      run(MULH,   1, ONES, 64'd3, 5'd17, 0);
      run(REM,    0, 64'd17, 64'hFFFF_FFFF_FFFF_FFFB, 5'd18, 0);
      run(DIV,    0, 64'hFFFF_FFFF_FFFF_FFEF, 64'd5, 5'd19, 0);
      run(DIV,    1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd20, 0);
      run(REMU,   1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd21, 0);
      run(DIVU,   0, ONES, 64'd3, 5'd22, 0);
      run(DIV,    1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_FFFF_FFF9, 5'd23, 0);
      run(REMU,   0, 64'd5, 64'd9, 5'd24, 0);
      run(REM,    1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000, 5'd25, 0);

      // flush in the same cycle as the response handshake consumes it
      issue(MULHU, 0, 64'hABCD, 64'h1_0000, 5'd26);
      finish_resp(0, 1'b1);

      // flush on CALC cycle 20, with a request offered in the same cycle
      issue(DIV, 0, 64'd1000, 64'd3, 5'd27);
      repeat (19) begin @(posedge clk); #1; end
      flush = 1'b1; req_valid = 1'b1; op = DIVU; word_op = 1'b0; rs1 = 64'd9; rs2 = 64'd3;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0; pend = 1'b0;
      repeat (70) begin @(posedge clk); #1; end
      run(REMU, 0, 64'd100, 64'd7, 5'd28, 0);
      check("remu after flush", result, 64'd2);

      // reset in the middle of an iterative divide
      issue(DIV, 0, 64'd12345, 64'd67, 5'd29);
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; pend = 1'b0;
      @(negedge clk);
      check("midreset result", result, 64'd0);
      check("midreset rd", {59'b0, rd_out}, 64'd0);
      check("midreset busy", {63'b0, busy}, 64'd0);
      @(posedge clk); #1;
      run(DIVU, 0, 64'd100, 64'd7, 5'd30, 0);
      repeat (3) begin @(posedge clk); #1; end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
